// File: rtl/ptpv2_pkg.sv
// Shared PTPv2 TX timestamp record layout and queue controller state encoding.
package ptpv2_pkg;

    localparam int unsigned TS_W  = 80;
    localparam int unsigned SEQ_W = 16;
    localparam int unsigned MSG_W = 4;
    localparam int unsigned SDO_W = 4;
    localparam int unsigned REC_W = TS_W + SEQ_W + MSG_W + SDO_W;
    localparam int unsigned TMR_W = 8;
    localparam int unsigned ERR_W = 8;

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [SEQ_W-1:0] seq_id;
        logic [MSG_W-1:0] msg_type;
        logic [SDO_W-1:0] sdo_id;
    } txts_rec_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } txts_state_e;

endpackage

// File: rtl/txts_fifo.sv
// Record FIFO for TX timestamps with registered head, level and full flag.
// TXTS_OVERWRITE_EN: a push at full replaces the oldest record instead of being dropped.
module txts_fifo
    import ptpv2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  txts_rec_t              push_data_i,
    input  logic                   pop_i,
    output txts_rec_t              head_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    txts_rec_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    txts_rec_t     head_q, head_d;
    logic          do_pop, do_write, rd_adv;

    // Pop is applied before push, so a same-cycle pop at full frees a slot.
    always_comb begin
        do_pop   = pop_i && (level_q != '0);
`ifdef TXTS_OVERWRITE_EN
        do_write = push_i;
        rd_adv   = do_pop || (push_i && full_q);
`else
        do_write = push_i && (!full_q || do_pop);
        rd_adv   = do_pop;
`endif
        wr_ptr_d = do_write ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_adv ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(do_write) - LW'(rd_adv);
        full_d   = (level_d == LW'(DEPTH));
        if (level_d == '0) begin
            head_d = '0;
        end else if (do_write && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            head_q   <= head_d;
        end
    end

    assign head_o  = head_q;
    assign level_o = level_q;
    assign full_o  = full_q;

endmodule

// File: rtl/txts_queue_ctrl.sv
// PTP TX timestamp capture: pairs SFD triggers with frame metadata and queues records.
// TXTS_OVERWRITE_EN (in txts_fifo) selects overwrite-oldest instead of drop at full.
module txts_queue_ctrl
    import ptpv2_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic                   rtc_clk,
    input  logic                   rtc_rst,
    input  logic [TS_W-1:0]        rtc_time_i,
    input  logic                   txts_trig_i,
    input  logic                   txts_valid_i,
    input  logic [SEQ_W-1:0]       tx_seqId_i,
    input  logic [MSG_W-1:0]       tx_messageType_i,
    input  logic [SDO_W-1:0]       tx_majorSdoId_i,
    input  logic                   int_en_i,
    input  logic                   pop_i,
    output logic [REC_W-1:0]       head_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [ERR_W-1:0]       err_cnt_o,
    output logic                   int_tx_ptp_o
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    txts_state_e      state_q, state_d;
    logic [TS_W-1:0]  ts_hold_q, ts_hold_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             int_q, int_d;
    logic             push, err_evt, err_inc;
    txts_rec_t        push_rec, head;
    logic [LW-1:0]    level;
    logic             fifo_full;

    // Trigger/valid pairing; only one error source can fire in a given cycle.
    always_comb begin
        state_d           = state_q;
        ts_hold_d         = ts_hold_q;
        timer_d           = timer_q;
        push              = 1'b0;
        err_evt           = 1'b0;
        push_rec.ts       = ts_hold_q;
        push_rec.seq_id   = tx_seqId_i;
        push_rec.msg_type = tx_messageType_i;
        push_rec.sdo_id   = tx_majorSdoId_i;
        case (state_q)
            ST_IDLE: begin
                if (txts_trig_i && txts_valid_i) begin
                    push        = 1'b1;
                    push_rec.ts = rtc_time_i;
                end else if (txts_trig_i) begin
                    ts_hold_d = rtc_time_i;
                    timer_d   = '0;
                    state_d   = ST_ARMED;
                end else if (txts_valid_i) begin
                    err_evt = 1'b1;
                end
            end
            ST_ARMED: begin
                if (txts_valid_i) begin
                    push = 1'b1;
                    if (txts_trig_i) begin
                        ts_hold_d = rtc_time_i;
                        timer_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (txts_trig_i) begin
                    ts_hold_d = rtc_time_i;
                    timer_d   = '0;
                    err_evt   = 1'b1;
                end else if (timer_q == TMR_W'(TMO_CYC - 1)) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                    err_evt = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        err_inc = err_evt || (push && fifo_full && !pop_i);
        err_d   = (err_inc && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
        int_d   = (level != '0) && int_en_i;
    end

    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) begin
            state_q   <= ST_IDLE;
            ts_hold_q <= '0;
            timer_q   <= '0;
            err_q     <= '0;
            int_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ts_hold_q <= ts_hold_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            int_q     <= int_d;
        end
    end

    txts_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i      (rtc_clk),
        .rst_i      (rtc_rst),
        .push_i     (push),
        .push_data_i(push_rec),
        .pop_i      (pop_i),
        .head_o     (head),
        .level_o    (level),
        .full_o     (fifo_full)
    );

    assign head_o       = head;
    assign level_o      = level;
    assign err_cnt_o    = err_q;
    assign int_tx_ptp_o = int_q;

endmodule

// File: tb/tb_txts_queue_ctrl.sv
// Self-checking bench for txts_queue_ctrl: directed scenarios plus random traffic vs a queue model.
module tb_txts_queue_ctrl;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TMO_CYC = 255;
    localparam int unsigned LW      = $clog2(DEPTH) + 1;

    logic          rtc_clk = 1'b0;
    logic          rtc_rst;
    logic [79:0]   rtc_time_i;
    logic          txts_trig_i;
    logic          txts_valid_i;
    logic [15:0]   tx_seqId_i;
    logic [3:0]    tx_messageType_i;
    logic [3:0]    tx_majorSdoId_i;
    logic          int_en_i;
    logic          pop_i;
    logic [103:0]  head_o;
    logic [LW-1:0] level_o;
    logic [7:0]    err_cnt_o;
    logic          int_tx_ptp_o;

    int checks = 0;
    int errors = 0;

    // Reference model: stored records, pending timestamp, cycles waited, error count.
    logic [103:0] m_q[$];
    bit           m_armed;
    logic [79:0]  m_hold;
    int           m_age;
    int           m_err;
    bit           m_int;

    logic [103:0] fill_rec [6];

    always #5 rtc_clk = ~rtc_clk;

    txts_queue_ctrl #(
        .DEPTH  (DEPTH),
        .TMO_CYC(TMO_CYC)
    ) dut (
        .rtc_clk         (rtc_clk),
        .rtc_rst         (rtc_rst),
        .rtc_time_i      (rtc_time_i),
        .txts_trig_i     (txts_trig_i),
        .txts_valid_i    (txts_valid_i),
        .tx_seqId_i      (tx_seqId_i),
        .tx_messageType_i(tx_messageType_i),
        .tx_majorSdoId_i (tx_majorSdoId_i),
        .int_en_i        (int_en_i),
        .pop_i           (pop_i),
        .head_o          (head_o),
        .level_o         (level_o),
        .err_cnt_o       (err_cnt_o),
        .int_tx_ptp_o    (int_tx_ptp_o)
    );

    function automatic logic [79:0] rand_ts();
        logic [79:0] t;
        t = {16'($urandom), $urandom, $urandom};
        return t;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_armed = 1'b0;
        m_hold  = '0;
        m_age   = 0;
        m_err   = 0;
        m_int   = 1'b0;
    endfunction

    function automatic void model_err();
        if (m_err < 255) m_err++;
    endfunction

    function automatic void model_edge(input bit trig, input bit valid, input bit pop,
                                       input bit en, input logic [79:0] t, input logic [23:0] meta);
        bit           do_push;
        logic [103:0] rec;
        do_push = 1'b0;
        rec     = '0;
        m_int   = (m_q.size() != 0) && en;
        if (valid && (m_armed || trig)) begin
            do_push = 1'b1;
            rec     = {(m_armed ? m_hold : t), meta};
            if (m_armed && trig) begin
                m_hold = t;
                m_age  = 0;
            end else begin
                m_armed = 1'b0;
            end
        end else if (valid) begin
            model_err();
        end else if (trig) begin
            if (m_armed) model_err();
            m_armed = 1'b1;
            m_hold  = t;
            m_age   = 0;
        end else if (m_armed) begin
            m_age++;
            if (m_age >= TMO_CYC) begin
                m_armed = 1'b0;
                model_err();
            end
        end
        if (pop && m_q.size() != 0) m_q.delete(0);
        if (do_push) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(rec);
            end else begin
                model_err();
`ifdef TXTS_OVERWRITE_EN
                m_q.delete(0);
                m_q.push_back(rec);
`endif
            end
        end
    endfunction

    task automatic step(input bit trig, input bit valid, input bit pop, input bit en,
                        input logic [79:0] t, input logic [23:0] meta);
        txts_trig_i  = trig;
        txts_valid_i = valid;
        pop_i        = pop;
        int_en_i     = en;
        rtc_time_i   = t;
        {tx_seqId_i, tx_messageType_i, tx_majorSdoId_i} = meta;
        @(posedge rtc_clk);
        model_edge(trig, valid, pop, en, t, meta);
        #1;
        txts_trig_i  = 1'b0;
        txts_valid_i = 1'b0;
        pop_i        = 1'b0;
    endtask

    task automatic do_reset();
        rtc_rst      = 1'b1;
        txts_trig_i  = 1'b0;
        txts_valid_i = 1'b0;
        pop_i        = 1'b0;
        int_en_i     = 1'b0;
        rtc_time_i   = '0;
        tx_seqId_i   = '0;
        tx_messageType_i = '0;
        tx_majorSdoId_i  = '0;
        @(posedge rtc_clk);
        @(posedge rtc_clk);
        #1;
        rtc_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (level_o !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level_o); end
        if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_cnt_o); end
        if (int_tx_ptp_o !== 1'b0) begin errors++; $display("FAIL reset_int: got %b expected 0", int_tx_ptp_o); end
        if (head_o !== 104'd0) begin errors++; $display("FAIL reset_head: got %h expected 0", head_o); end
    endtask

    task automatic test_basic();
        logic [79:0]  ts;
        logic [103:0] exp_head;
        ts       = 80'h0000_0000_0001_1234_5678;
        exp_head = {ts, 16'h0042, 4'h0, 4'h5};
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b1, rand_ts(), 24'h0);
        checks += 2;
        if (level_o !== '0) begin errors++; $display("FAIL pop_empty_level: got %0d expected 0", level_o); end
        if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL pop_empty_err: got %0d expected 0", err_cnt_o); end
        step(1'b1, 1'b0, 1'b0, 1'b1, ts, 24'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, rand_ts(), 24'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, rand_ts(), 24'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, rand_ts(), {16'h0042, 4'h0, 4'h5});
        checks += 4;
        if (level_o !== LW'(1)) begin errors++; $display("FAIL basic_level: got %0d expected 1", level_o); end
        if (head_o !== exp_head) begin errors++; $display("FAIL basic_head: got %h expected %h", head_o, exp_head); end
        if (int_tx_ptp_o !== 1'b0) begin errors++; $display("FAIL basic_int_early: got %b expected 0", int_tx_ptp_o); end
        if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL basic_err: got %0d expected 0", err_cnt_o); end
        step(1'b0, 1'b0, 1'b0, 1'b1, rand_ts(), 24'h0);
        checks += 1;
        if (int_tx_ptp_o !== 1'b1) begin errors++; $display("FAIL basic_int: got %b expected 1", int_tx_ptp_o); end
        step(1'b0, 1'b0, 1'b1, 1'b1, rand_ts(), 24'h0);
        checks += 1;
        if (level_o !== '0) begin errors++; $display("FAIL basic_pop_level: got %0d expected 0", level_o); end
    endtask

    task automatic test_timeout();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, rand_ts(), 24'h0);
        repeat (TMO_CYC - 1) step(1'b0, 1'b0, 1'b0, 1'b0, rand_ts(), 24'h0);
        checks += 1;
        if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL tmo_early_err: got %0d expected 0", err_cnt_o); end
        step(1'b0, 1'b0, 1'b0, 1'b0, rand_ts(), 24'h0);
        checks += 2;
        if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL tmo_err: got %0d expected 1", err_cnt_o); end
        if (level_o !== '0) begin errors++; $display("FAIL tmo_level: got %0d expected 0", level_o); end
        step(1'b0, 1'b1, 1'b0, 1'b0, rand_ts(), 24'h123456);
        checks += 2;
        if (err_cnt_o !== 8'd2) begin errors++; $display("FAIL tmo_valid_err: got %0d expected 2", err_cnt_o); end
        if (level_o !== '0) begin errors++; $display("FAIL tmo_valid_level: got %0d expected 0", level_o); end
    endtask

    task automatic test_fill();
        logic [79:0]  ts;
        logic [23:0]  meta;
        logic [103:0] exp_head;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ts   = rand_ts();
            meta = {16'(i + 1), 4'(i), 4'(15 - i)};
            fill_rec[i] = {ts, meta};
            step(1'b1, 1'b0, 1'b0, 1'b0, ts, 24'h0);
            step(1'b0, 1'b1, 1'b0, 1'b0, rand_ts(), meta);
        end
`ifdef TXTS_OVERWRITE_EN
        exp_head = fill_rec[1];
`else
        exp_head = fill_rec[0];
`endif
        checks += 3;
        if (level_o !== LW'(4)) begin errors++; $display("FAIL fill_level: got %0d expected 4", level_o); end
        if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL fill_err: got %0d expected 1", err_cnt_o); end
        if (head_o !== exp_head) begin errors++; $display("FAIL fill_head: got %h expected %h", head_o, exp_head); end
    endtask

    task automatic test_full_pop_push();
        logic [79:0]  ts;
        logic [103:0] exp_head;
        ts = rand_ts();
        fill_rec[5] = {ts, 24'hABCDEF};
        step(1'b1, 1'b0, 1'b0, 1'b0, ts, 24'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, rand_ts(), 24'hABCDEF);
`ifdef TXTS_OVERWRITE_EN
        exp_head = fill_rec[2];
`else
        exp_head = fill_rec[1];
`endif
        checks += 3;
        if (level_o !== LW'(4)) begin errors++; $display("FAIL fullpp_level: got %0d expected 4", level_o); end
        if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL fullpp_err: got %0d expected 1", err_cnt_o); end
        if (head_o !== exp_head) begin errors++; $display("FAIL fullpp_head: got %h expected %h", head_o, exp_head); end
    endtask

    task automatic test_retrig();
        logic [79:0] ts_a, ts_b;
        ts_a = rand_ts();
        ts_b = ts_a ^ 80'hFFFF_0000_FFFF_0000_FFFF;
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, ts_a, 24'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, ts_b, 24'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, rand_ts(), 24'h777123);
        checks += 3;
        if (head_o !== {ts_b, 24'h777123}) begin errors++; $display("FAIL retrig_head: got %h expected %h", head_o, {ts_b, 24'h777123}); end
        if (level_o !== LW'(1)) begin errors++; $display("FAIL retrig_level: got %0d expected 1", level_o); end
        if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL retrig_err: got %0d expected 1", err_cnt_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1, rand_ts(), 24'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, rand_ts(), 24'(i));
        step(1'b1, 1'b0, 1'b0, 1'b1, rand_ts(), 24'h0);
        checks += 3;
        if (level_o !== LW'(3)) begin errors++; $display("FAIL mid_pre_level: got %0d expected 3", level_o); end
        if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL mid_pre_err: got %0d expected 1", err_cnt_o); end
        if (int_tx_ptp_o !== 1'b1) begin errors++; $display("FAIL mid_pre_int: got %b expected 1", int_tx_ptp_o); end
        #2;
        rtc_rst = 1'b1;
        #1;
        checks += 4;
        if (level_o !== '0) begin errors++; $display("FAIL mid_level: got %0d expected 0", level_o); end
        if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL mid_err: got %0d expected 0", err_cnt_o); end
        if (int_tx_ptp_o !== 1'b0) begin errors++; $display("FAIL mid_int: got %b expected 0", int_tx_ptp_o); end
        if (head_o !== 104'd0) begin errors++; $display("FAIL mid_head: got %h expected 0", head_o); end
        @(posedge rtc_clk);
        #1;
        rtc_rst = 1'b0;
        model_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1, rand_ts(), 24'h555555);
        checks += 2;
        if (level_o !== '0) begin errors++; $display("FAIL mid_valid_level: got %0d expected 0", level_o); end
        if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL mid_valid_err: got %0d expected 1", err_cnt_o); end
    endtask

    task automatic test_err_saturate();
        do_reset();
        repeat (260) step(1'b0, 1'b1, 1'b0, 1'b0, rand_ts(), 24'h0);
        checks += 1;
        if (err_cnt_o !== 8'd255) begin errors++; $display("FAIL err_sat: got %0d expected 255", err_cnt_o); end
    endtask

    task automatic test_random();
        bit trig, valid, pop, en;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            trig  = ($urandom_range(99) < 30);
            valid = ($urandom_range(99) < 30);
            pop   = ($urandom_range(99) < 22);
            en    = ($urandom_range(99) < 80);
            step(trig, valid, pop, en, rand_ts(), 24'($urandom));
            checks += 3;
            if (level_o !== LW'(m_q.size())) begin errors++; $display("FAIL rand_level@%0d: got %0d expected %0d", n, level_o, m_q.size()); end
            if (err_cnt_o !== 8'(m_err)) begin errors++; $display("FAIL rand_err@%0d: got %0d expected %0d", n, err_cnt_o, m_err); end
            if (int_tx_ptp_o !== m_int) begin errors++; $display("FAIL rand_int@%0d: got %b expected %b", n, int_tx_ptp_o, m_int); end
            if (m_q.size() != 0) begin
                checks++;
                if (head_o !== m_q[0]) begin errors++; $display("FAIL rand_head@%0d: got %h expected %h", n, head_o, m_q[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_fill();
        test_full_pop_push();
        test_retrig();
        test_reset_mid();
        test_err_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/txts_queue_ctrl.md
TXTS_QUEUE_CTRL -- requirements
Module: txts_queue_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, record FIFO depth; power of two, 2..16.
REQ-002 Parameter TMO_CYC, default 255, max cycles from trigger to valid; range 1..255.
REQ-003 rtc_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 rtc_rst  in  1  asynchronous, active-high reset.
REQ-005 rtc_time_i  in  80  current RTC time: 48 b seconds + 32 b nanoseconds.
REQ-006 txts_trig_i  in  1  single-cycle pulse: TX SFD timestamp point.
REQ-007 txts_valid_i  in  1  single-cycle pulse: frame confirmed PTP, metadata valid.
REQ-008 tx_seqId_i  in  16  sequenceId, sampled on txts_valid_i.
REQ-009 tx_messageType_i  in  4  messageType, sampled on txts_valid_i.
REQ-010 tx_majorSdoId_i  in  4  majorSdoId, sampled on txts_valid_i.
REQ-011 int_en_i  in  1  interrupt enable.
REQ-012 pop_i  in  1  single-cycle pulse: CPU consumed the head record.
REQ-013 head_o  out  104  head record {ts[79:0], seqId[15:0], msgType[3:0], sdoId[3:0]}.
REQ-014 level_o  out  $clog2(DEPTH)+1  number of stored records.
REQ-015 err_cnt_o  out  8  saturating count of overflow, timeout and protocol errors.
REQ-016 int_tx_ptp_o  out  1  interrupt, registered.

Function
REQ-017 FSM states: IDLE and ARMED.
REQ-018 IDLE with txts_trig_i: latch rtc_time_i into ts_hold, clear timer, go to ARMED.
REQ-019 ARMED with txts_valid_i: push {ts_hold, metadata}, go to IDLE.
REQ-020 trig and valid together in IDLE: push {rtc_time_i, metadata}, stay IDLE.
REQ-021 ARMED with trig and no valid: re-latch ts_hold (newest wins), restart timer, err_cnt +1.
REQ-022 ARMED with trig and valid together: push ts_hold, re-latch rtc_time_i, stay ARMED.
REQ-023 IDLE with valid and no trig: no push, err_cnt +1.
REQ-024 ARMED: timer +1 per cycle; on reaching TMO_CYC with no valid, discard, go to IDLE, err_cnt +1.
REQ-025 Push-to-head latency: 1 cycle; head_o and level_o update the cycle after the push.
REQ-026 pop_i with level 0: ignored, no error.
REQ-027 Same-cycle push and pop at full: pop first, then push; no overflow; level unchanged.
REQ-028 Push at full without pop: behaviour set by REQ-033/REQ-034; err_cnt +1.
REQ-029 Pointers wrap modulo DEPTH; err_cnt saturates at 255, no wrap.
REQ-030 int_tx_ptp_o = registered (level != 0 && int_en_i); one cycle behind level_o.

Reset
REQ-031 On rtc_rst: FSM IDLE; pointers, level_o, timer, err_cnt_o, int_tx_ptp_o all 0; head_o 0; FIFO contents discarded.
REQ-032 Reset asserted mid-operation (ARMED or FIFO non-empty) takes effect immediately; no partial push completes.

Configuration
REQ-033 TXTS_OVERWRITE_EN defined: push at full overwrites the oldest record (read pointer advances); level stays DEPTH; head_o shows the new oldest record.
REQ-034 TXTS_OVERWRITE_EN undefined: push at full dropped; FIFO unchanged.

Structure
REQ-035 Shared package ptpv2_pkg holds: the record field widths (TS 80, SEQ 16, MSG 4, SDO 4), the record width 104, and the FSM state encoding.
REQ-036 One sub-module, txts_fifo, implements the storage, pointers, level and full/empty logic, including the overwrite option; txts_queue_ctrl holds the FSM, timer, error counter and interrupt.

Verification
REQ-037 trig with rtc_time=0x0000_0000_0001_1234_5678; valid 3 cycles later with seqId=0x0042, msgType=0x0 -> head_o = {that ts, 0x0042, 0x0, sdo}; level 1; int asserted 1 cycle after level when int_en=1.
REQ-038 trig, no valid for 255 cycles -> FSM IDLE, level 0, err_cnt 1; valid on the next cycle -> err_cnt 2, no push.
REQ-039 5 trig/valid pairs, DEPTH=4, no pops -> level 4, err_cnt 1; head = record 1 without the macro, record 2 with it.
REQ-040 At full, pop and push in the same cycle -> level stays 4, err_cnt unchanged, head advances by one record.
REQ-041 Second trig at ts=B while ARMED with ts=A, then valid -> pushed ts = B; err_cnt 1.
REQ-042 rtc_rst asserted while ARMED with level 3 -> all outputs 0 immediately; a later valid with no trig -> no push.
